// File: rtl/transmission_pkg.sv
// Shared types and constants for the transmission8 distributor sequencer.
package transmission_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CH_W = 3;
   localparam int NUM_CH = 8;
   localparam logic [7:0] IDLE_WORD_DEF = 8'hFF;

endpackage

// File: rtl/transmission8_scan_ctrl_chan_next_find.sv
// Finds the lowest enabled channel at or above channel 0 (first=1),
// or strictly above cur (first=0).
module chan_next_find
   import transmission_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [CH_W-1:0]   cur,
   input  logic              first,
   output logic [CH_W-1:0]   nxt,
   output logic              found
);

   always_comb begin
      nxt = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && mask[i] && (first || (CH_W'(i) > cur))) begin
            found = 1'b1;
            nxt = CH_W'(i);
         end
      end
   end

endmodule

// File: rtl/transmission8_scan_ctrl.sv
// Frame sequencer for the 8-channel distributor: latches a word and mask,
// then walks the select lines through each enabled channel once.
module transmission8_scan_ctrl
   import transmission_pkg::*;
#(
   parameter int SLOT_CYCLES = 4,
   parameter logic [7:0] IDLE_WORD = IDLE_WORD_DEF
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic [7:0] in_mask,
   input  logic       abort,
   output logic [7:0] data_o,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       busy,
   output logic       done
);

   localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       word_q;
   logic [7:0]       mask_q;
   logic [CH_W-1:0]  sel;
   logic [CH_W-1:0]  nxt;
   logic             found;
   logic             in_idle;

   assign {A, B, C} = sel;
   assign in_idle = (state == IDLE);

   // In IDLE the search runs on the incoming mask so the first channel is
   // ready on the accepting edge; in SCAN it looks above the current channel.
   chan_next_find u_find (
      .mask  (in_idle ? in_mask : mask_q),
      .cur   (sel),
      .first (in_idle),
      .nxt   (nxt),
      .found (found)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         data_o   <= IDLE_WORD;
         sel      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         in_ready <= 1'b1;
         cnt      <= '0;
         word_q   <= '0;
         mask_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (in_valid) begin
                  word_q   <= in_data;
                  mask_q   <= in_mask;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  if (found) begin
                     state  <= SCAN;
                     sel    <= nxt;
                     data_o <= in_data;
                     busy   <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (abort) begin
                  state    <= IDLE;
                  data_o   <= IDLE_WORD;
                  sel      <= '0;
                  busy     <= 1'b0;
                  in_ready <= 1'b1;
                  cnt      <= '0;
               end else if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (found) begin
                     sel    <= nxt;
                     data_o <= word_q;
                  end else begin
                     state  <= DONE;
                     done   <= 1'b1;
                     busy   <= 1'b0;
                     data_o <= IDLE_WORD;
                     sel    <= '0;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               state    <= IDLE;
               done     <= 1'b0;
               in_ready <= 1'b1;
            end
            default: begin
               state    <= IDLE;
               data_o   <= IDLE_WORD;
               sel      <= '0;
               busy     <= 1'b0;
               done     <= 1'b0;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_transmission8_scan_ctrl.sv
// Directed bench for transmission8_scan_ctrl with a trace-queue reference model.
module tb_transmission8_scan_ctrl;

   localparam int SLOT = 4;

   typedef struct packed {
      logic [7:0] data;
      logic [2:0] sel;
      logic       busy;
      logic       done;
      logic       ready;
   } exp_t;

   localparam exp_t IDLE_E = {8'hFF, 3'd0, 1'b0, 1'b0, 1'b1};
   localparam exp_t DONE_E = {8'hFF, 3'd0, 1'b0, 1'b1, 1'b0};

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [7:0] in_mask;
   logic       abort;
   logic [7:0] data_o;
   logic       A, B, C;
   logic       busy;
   logic       done;

   int   n_cmp = 0;
   int   n_err = 0;
   logic check_en = 1'b0;
   exp_t cur_exp = IDLE_E;
   exp_t exp_q[$];

   transmission8_scan_ctrl #(.SLOT_CYCLES(SLOT), .IDLE_WORD(8'hFF)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_mask  (in_mask),
      .abort    (abort),
      .data_o   (data_o),
      .A        (A),
      .B        (B),
      .C        (C),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The model expands an accepted frame into its full cycle-by-cycle trace.
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         cur_exp = IDLE_E;
      end else if (cur_exp.busy && abort) begin
         exp_q.delete();
         cur_exp = IDLE_E;
      end else if (exp_q.size() > 0) begin
         cur_exp = exp_q.pop_front();
      end else if (cur_exp.ready && in_valid) begin
         for (int ch = 0; ch < 8; ch++)
            if (in_mask[ch])
               for (int k = 0; k < SLOT; k++)
                  exp_q.push_back({in_data, 3'(ch), 1'b1, 1'b0, 1'b0});
         exp_q.push_back(DONE_E);
         cur_exp = exp_q.pop_front();
      end else begin
         cur_exp = IDLE_E;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         n_cmp++;
         if (data_o !== cur_exp.data || {A, B, C} !== cur_exp.sel || busy !== cur_exp.busy ||
             done !== cur_exp.done || in_ready !== cur_exp.ready) begin
            n_err++;
            $display("[TB] FAIL model_cmp t=%0t got data=%h sel=%0d busy=%b done=%b ready=%b want data=%h sel=%0d busy=%b done=%b ready=%b",
                     $time, data_o, {A, B, C}, busy, done, in_ready,
                     cur_exp.data, cur_exp.sel, cur_exp.busy, cur_exp.done, cur_exp.ready);
         end
      end
   end

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [7:0] m, input logic a);
      in_valid = v;
      in_data = d;
      in_mask = m;
      abort = a;
      @(negedge clk);
   endtask

   task automatic idleCycles(input int n);
      in_valid = 1'b0;
      abort = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] d, input logic [2:0] s,
                              input logic b, input logic dn, input logic r);
      n_cmp++;
      if (data_o !== d || {A, B, C} !== s || busy !== b || done !== dn || in_ready !== r) begin
         n_err++;
         $display("[TB] FAIL %s got data=%h sel=%0d busy=%b done=%b ready=%b want data=%h sel=%0d busy=%b done=%b ready=%b",
                  name, data_o, {A, B, C}, busy, done, in_ready, d, s, b, dn, r);
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      in_mask = 8'h00;
      abort = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset", 8'hFF, 3'd0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      check_en = 1'b1;

      // Full mask: eight slots of four cycles each
      applyStimulus(1'b1, 8'hA5, 8'hFF, 1'b0);
      checkOutput("full_first", 8'hA5, 3'd0, 1'b1, 1'b0, 1'b0);
      idleCycles(4);
      checkOutput("full_ch1", 8'hA5, 3'd1, 1'b1, 1'b0, 1'b0);
      idleCycles(27);
      checkOutput("full_last", 8'hA5, 3'd7, 1'b1, 1'b0, 1'b0);
      idleCycles(1);
      checkOutput("full_done", 8'hFF, 3'd0, 1'b0, 1'b1, 1'b0);
      idleCycles(1);
      checkOutput("full_idle", 8'hFF, 3'd0, 1'b0, 1'b0, 1'b1);

      // Sparse mask: channels 1 and 7 only
      applyStimulus(1'b1, 8'h5A, 8'b1000_0010, 1'b0);
      checkOutput("sparse_ch1", 8'h5A, 3'd1, 1'b1, 1'b0, 1'b0);
      idleCycles(4);
      checkOutput("sparse_ch7", 8'h5A, 3'd7, 1'b1, 1'b0, 1'b0);
      idleCycles(4);
      checkOutput("sparse_done", 8'hFF, 3'd0, 1'b0, 1'b1, 1'b0);
      idleCycles(2);

      // Empty mask goes straight to the done pulse
      applyStimulus(1'b1, 8'h77, 8'h00, 1'b0);
      checkOutput("empty_done", 8'hFF, 3'd0, 1'b0, 1'b1, 1'b0);
      idleCycles(1);
      checkOutput("empty_idle", 8'hFF, 3'd0, 1'b0, 1'b0, 1'b1);

      // Abort while channel 3 is selected
      applyStimulus(1'b1, 8'hC3, 8'hFF, 1'b0);
      idleCycles(12);
      checkOutput("abort_pre", 8'hC3, 3'd3, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'hC3, 8'hFF, 1'b1);
      checkOutput("abort_idle", 8'hFF, 3'd0, 1'b0, 1'b0, 1'b1);
      idleCycles(40);

      // Abort coinciding with in_valid in IDLE still accepts the frame
      applyStimulus(1'b1, 8'h96, 8'h0C, 1'b1);
      checkOutput("abort_accept", 8'h96, 3'd2, 1'b1, 1'b0, 1'b0);
      idleCycles(8);
      checkOutput("abort_accept_done", 8'hFF, 3'd0, 1'b0, 1'b1, 1'b0);
      idleCycles(1);

      // in_valid held through the scan with changed data
      applyStimulus(1'b1, 8'h11, 8'h03, 1'b0);
      checkOutput("hold_first", 8'h11, 3'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h3C, 8'h03, 1'b0);
      checkOutput("hold_ignored", 8'h11, 3'd0, 1'b1, 1'b0, 1'b0);
      repeat (7) @(negedge clk);
      checkOutput("hold_done", 8'hFF, 3'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("hold_idle", 8'hFF, 3'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("hold_relatch", 8'h3C, 3'd0, 1'b1, 1'b0, 1'b0);
      idleCycles(8);
      checkOutput("hold_relatch_done", 8'hFF, 3'd0, 1'b0, 1'b1, 1'b0);
      idleCycles(1);

      // Reset while channel 5 is selected, then a fresh frame
      applyStimulus(1'b1, 8'hE7, 8'hFF, 1'b0);
      idleCycles(20);
      checkOutput("rst_pre", 8'hE7, 3'd5, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_mid", 8'hFF, 3'd0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      applyStimulus(1'b1, 8'h2B, 8'h50, 1'b0);
      checkOutput("post_rst_ch4", 8'h2B, 3'd4, 1'b1, 1'b0, 1'b0);
      idleCycles(4);
      checkOutput("post_rst_ch6", 8'h2B, 3'd6, 1'b1, 1'b0, 1'b0);
      idleCycles(4);
      checkOutput("post_rst_done", 8'hFF, 3'd0, 1'b0, 1'b1, 1'b0);
      idleCycles(2);

      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
